ram_reader: RTL
===============

# ram_reader

Sequential reader for the shared synchronous RAM, the read-side counterpart of the RAM initializer. On `start` it walks addresses 0 to RAM_SIZE-1 and absorbs the RAM's one-cycle read latency. Words are delivered in address order on a valid/ready stream through a 2-entry buffer. The block plugs into the RAM controller's device bus with the same start/finished, write-enable and address contract as the other devices, and it never writes.

## Interface
- `RAM_WIDTH`, 8: data word width.
- `ADDR_WIDTH`, 8: address width; requires 2**ADDR_WIDTH >= RAM_SIZE.
- `RAM_SIZE`, 256: number of words read per run; legal range 1..2**ADDR_WIDTH.
- `clk` input 1: single clock; all logic is rising-edge.
- `reset` input 1: asynchronous, active-low; when low, the whole block is immediately forced to reset state.
- `start` input 1: begin a run; sampled only in IDLE.
- `finished` output 1: one-cycle pulse after the last word is accepted downstream.
- `write_enable` output 1: RAM write enable; constant 0.
- `address` output ADDR_WIDTH: RAM read address, driven from a register.
- `q` input RAM_WIDTH: RAM read data, valid the cycle after an address is issued.
- `out_data` output RAM_WIDTH: head word of the buffer.
- `out_valid` output 1: `out_data` is valid.
- `out_ready` input 1: downstream accepts; a pop occurs when `out_valid && out_ready`.
- `mismatch_count` output ADDR_WIDTH+1: data-check mismatches, saturating (see Configuration).
- `error` output 1: sticky flag, set on any mismatch (see Configuration).

## Operation
- States and transitions:
  - IDLE -> READ when `start`=1.
  - READ -> DRAIN after address RAM_SIZE-1 is issued.
  - DRAIN -> DONE when the buffer is empty, no read is in flight, and a pop of the last word occurs.
  - DONE -> IDLE unconditionally; `finished`=1 only in DONE.
- Issue rule in READ: issue the current address when `occupancy + inflight - pop < 2`. `inflight` is 0 or 1 and means an address was issued last cycle. On issue, `address` increments in the following cycle; it never wraps and holds at RAM_SIZE-1 after the last issue.
- Capture: while `inflight`=1, `q` is written into the buffer at the end of that cycle. The issue rule guarantees the buffer never overflows, so there is no drop or back-pressure path toward the RAM.
- Buffer: 2-entry FIFO, first in first out. Push and pop in the same cycle are both honoured.
- `start` in any state other than IDLE is ignored.
- `out_ready`=1 while `out_valid`=0 has no effect.
- `out_ready` held low stalls issue once the buffer plus in-flight read reach 2. `address` then holds its value.
- Reset, asserted at any time including mid-run:
  - state=IDLE, buffer flushed, inflight=0.
  - `address`=0, `write_enable`=0, `out_valid`=0, `out_data`=0, `finished`=0, `mismatch_count`=0, `error`=0.

## Timing
- Start-to-first-output latency:
  - cycle 0: `start` sampled in IDLE.
  - cycle 1: READ, address 0 issued.
  - cycle 2: `q`=RAM[0] captured.
  - cycle 3: `out_valid`=1 with `out_data`=RAM[0].
- Throughput: one word per cycle while `out_ready`=1, so the last word is presented in cycle RAM_SIZE+2.
- `finished` pulses in the cycle after the last pop. With `out_ready` held at 1, that is cycle RAM_SIZE+3. The block is back in IDLE the following cycle.
- A new `start` is accepted on the first IDLE cycle; there is no extra dead cycle.

## Configuration
- `RAM_READER_CHECK_EN` defined:
  - Each popped word is compared against the low RAM_WIDTH bits of its address index (the initializer pattern S[i]=i).
  - On a mismatch, `mismatch_count` increments, saturating at all-ones, and `error` is set.
  - Both `mismatch_count` and `error` are cleared in the cycle `start` is accepted.
- `RAM_READER_CHECK_EN` undefined: `mismatch_count` and `error` are tied to 0, there is no compare logic, and the ports remain present.

## Test plan
- Initialized RAM (S[i]=i, 256 words), `out_ready`=1, pulse `start` → words 0..255 appear in cycles 3..258, `finished` pulses in cycle 259, `write_enable` is 0 throughout, and with check enabled `error`=0.
- Same RAM, `out_ready` low for cycles 5..20 → `address` freezes with at most 2 words buffered, nothing is dropped or duplicated, and all 256 words arrive in order.
- `out_ready` toggled 1010… → each word is delivered exactly once, and the count of popped words is 256 at `finished`.
- RAM[17]=0xFF and RAM[200]=0x00, check enabled → `mismatch_count`=2 and `error`=1 at `finished`. A second `start` clears both in its accept cycle.
- `reset` low at cycle 100 of a run → all outputs are at reset values in the same cycle. After release, `start` yields a full fresh run beginning at word 0.
- RAM_SIZE=1, `start` pulsed again in cycle 2 → one word is output, the second `start` is ignored, and `finished` pulses in cycle 4.

Source files
------------

// File: rtl/ram_reader.sv
// ram_reader: walks RAM addresses 0..RAM_SIZE-1 after start, absorbs the
// one-cycle RAM read latency and streams words out through a 2-entry FIFO.
// Optional data check against the initializer pattern S[i]=i is enabled
// by defining RAM_READER_CHECK_EN.
module ram_reader #(
   parameter int RAM_WIDTH  = 8,
   parameter int ADDR_WIDTH = 8,
   parameter int RAM_SIZE   = 256
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   output logic                  finished,
   output logic                  write_enable,
   output logic [ADDR_WIDTH-1:0] address,
   input  logic [RAM_WIDTH-1:0]  q,
   output logic [RAM_WIDTH-1:0]  out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ADDR_WIDTH:0]   mismatch_count,
   output logic                  error
);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_e;

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_SIZE - 1);

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  inflight_q;
   logic [RAM_WIDTH-1:0]  buf_q [2];
   logic                  wr_ptr_q, rd_ptr_q;
   logic [1:0]            cnt_q, cnt_d;
   logic                  issue, pop, push, start_acc, last_pop;

   assign pop          = out_valid & out_ready;
   assign push         = inflight_q;
   assign start_acc    = (state_q == S_IDLE) & start;
   // Last word leaves the buffer with nothing left behind it.
   assign last_pop     = (cnt_q == 2'd1) & pop & ~inflight_q;
   assign out_valid    = (cnt_q != 2'd0);
   assign out_data     = out_valid ? buf_q[rd_ptr_q] : '0;
   assign write_enable = 1'b0;
   assign address      = addr_q;

   // FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_READ;
         S_READ:  if (issue && addr_q == LAST_ADDR) state_d = S_DRAIN;
         S_DRAIN: if (last_pop) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM outputs: issue only while buffer plus in-flight read stays below 2
   always_comb begin
      issue    = 1'b0;
      finished = 1'b0;
      case (state_q)
         S_READ:  issue = (3'(cnt_q) + 3'(inflight_q)) < (3'd2 + 3'(pop));
         S_DONE:  finished = 1'b1;
         default: ;
      endcase
   end

   // Address next value: rewind on start, advance on issue, hold at last
   always_comb begin
      addr_d = addr_q;
      if (start_acc)                         addr_d = '0;
      else if (issue && addr_q != LAST_ADDR) addr_d = addr_q + 1'b1;
   end

   // Address register and in-flight flag (read issued last cycle)
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr_q     <= '0;
         inflight_q <= 1'b0;
      end else begin
         addr_q     <= addr_d;
         inflight_q <= issue;
      end
   end

   assign cnt_d = cnt_q + 2'(push) - 2'(pop);

   // 2-entry FIFO; push and pop in the same cycle are both honoured
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 2; i++) buf_q[i] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         if (push) begin
            buf_q[wr_ptr_q] <= q;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop) rd_ptr_q <= ~rd_ptr_q;
         cnt_q <= cnt_d;
      end
   end

`ifdef RAM_READER_CHECK_EN
   logic [ADDR_WIDTH-1:0] pop_idx_q;
   logic [ADDR_WIDTH:0]   mm_cnt_q;
   logic                  err_q;

   // Compare each popped word with its index; saturating count, sticky flag
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pop_idx_q <= '0;
         mm_cnt_q  <= '0;
         err_q     <= 1'b0;
      end else if (start_acc) begin
         pop_idx_q <= '0;
         mm_cnt_q  <= '0;
         err_q     <= 1'b0;
      end else if (pop) begin
         pop_idx_q <= pop_idx_q + 1'b1;
         if (out_data != RAM_WIDTH'(pop_idx_q)) begin
            err_q <= 1'b1;
            if (mm_cnt_q != '1) mm_cnt_q <= mm_cnt_q + 1'b1;
         end
      end
   end

   assign mismatch_count = mm_cnt_q;
   assign error          = err_q;
`else
   assign mismatch_count = '0;
   assign error          = 1'b0;
`endif

endmodule
